tmds_channel_decoder: RTL and testbench

Receive-side counterpart to the DVI output path: recovers one TMDS channel from a stream of unaligned 10-bit parallel words delivered by an external deserializer at pixel rate. The block:
- finds the 10-bit symbol boundary using control-token runs, and holds lock;
- performs TMDS 10b→8b data decoding and control-token decoding;
- presents pixel byte, control pair and data-enable.

Three instances, one per channel, sit behind the deserializers in the capture path.

---
 rtl/tmds_pkg.sv | 51 +++++
 rtl/tmds_word_aligner.sv | 47 ++++
 rtl/tmds_channel_decoder.sv | 137 +++++++++++++
 tb/tb_tmds_channel_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, receive FSM states and the 10b->8b
// decode helpers. The transmit-side encoder imports the same token constants.
package tmds_pkg;

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  localparam int SYM_W  = 10;
  localparam int BYTE_W = 8;
  localparam int OFS_W  = 4;
  localparam logic [OFS_W-1:0] OFS_MAX = 4'd9;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_token;
    logic [1:0] pair;
  } ctrl_dec_t;

  function automatic logic [BYTE_W-1:0] tmds_decode_data(input logic [SYM_W-1:0] q);
    logic [BYTE_W-1:0] d;
    logic [BYTE_W-1:0] r;
    d    = q[9] ? ~q[7:0] : q[7:0];
    r    = '0;
    r[0] = d[0];
    for (int i = 1; i < BYTE_W; i++) begin
      r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return r;
  endfunction

  function automatic ctrl_dec_t tmds_decode_ctrl(input logic [SYM_W-1:0] q);
    ctrl_dec_t r;
    r.is_token = 1'b1;
    r.pair     = 2'b00;
    case (q)
      TOKEN_00: r.pair = 2'b00;
      TOKEN_01: r.pair = 2'b01;
      TOKEN_10: r.pair = 2'b10;
      TOKEN_11: r.pair = 2'b11;
      default:  r.is_token = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Bit-slip word aligner: keeps the previous deserializer word, selects a
// 10-bit window at the current offset and registers it as stage 1.
module tmds_word_aligner
  import tmds_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] raw_in,
  input  logic [OFS_W-1:0] offset,
  output logic [SYM_W-1:0] word
);

  logic [SYM_W-1:0]   raw_prev;
  logic [2*SYM_W-1:0] window;
  logic [SYM_W-1:0]   aligned;

  assign window = {raw_in, raw_prev};

  // Explicit mux keeps out-of-range offsets from indexing past the window.
  always_comb begin
    aligned = window[9:0];
    case (offset)
      4'd0: aligned = window[9:0];
      4'd1: aligned = window[10:1];
      4'd2: aligned = window[11:2];
      4'd3: aligned = window[12:3];
      4'd4: aligned = window[13:4];
      4'd5: aligned = window[14:5];
      4'd6: aligned = window[15:6];
      4'd7: aligned = window[16:7];
      4'd8: aligned = window[17:8];
      4'd9: aligned = window[18:9];
      default: aligned = window[9:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_prev <= '0;
      word     <= '0;
    end else begin
      raw_prev <= raw_in;
      word     <= aligned;
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: symbol alignment FSM, lock supervision and
// registered 10b->8b / control-token decode behind the word aligner.
//
//   state  | meaning
//   SEARCH | hunting for CTRL_RUN consecutive tokens; slips offset every DWELL cycles
//   LOCKED | alignment held; drops after LOSS_TIMEOUT cycles with no token
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN     = 16,
  parameter int DWELL        = 4096,
  parameter int LOSS_TIMEOUT = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SYM_W-1:0]  raw_in,
  output logic [BYTE_W-1:0] data,
  output logic [1:0]        ctrl,
  output logic              de,
  output logic              locked,
  output logic [OFS_W-1:0]  offset
);

  localparam int RUN_W   = $clog2(CTRL_RUN) + 1;
  localparam int DWELL_W = $clog2(DWELL) + 1;
  localparam int TMO_W   = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_RUN - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOSS_TIMEOUT - 1);

  state_t             state, state_next;
  logic [RUN_W-1:0]   run_cnt, run_next;
  logic [DWELL_W-1:0] dwell_cnt, dwell_next;
  logic [TMO_W-1:0]   tmo_cnt, tmo_next;
  logic [OFS_W-1:0]   offset_next;

  logic [SYM_W-1:0]   word;
  ctrl_dec_t          cdec;
  logic [BYTE_W-1:0]  ddec;

  logic [BYTE_W-1:0]  data_next;
  logic [1:0]         ctrl_next;
  logic               de_next;

  tmds_word_aligner u_aligner (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .offset (offset),
    .word   (word)
  );

  assign cdec = tmds_decode_ctrl(word);
  assign ddec = tmds_decode_data(word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      dwell_cnt <= '0;
      tmo_cnt   <= '0;
      offset    <= '0;
    end else begin
      state     <= state_next;
      run_cnt   <= run_next;
      dwell_cnt <= dwell_next;
      tmo_cnt   <= tmo_next;
      offset    <= offset_next;
    end
  end

  always_comb begin
    state_next  = state;
    run_next    = run_cnt;
    dwell_next  = dwell_cnt;
    tmo_next    = tmo_cnt;
    offset_next = offset;
    case (state)
      SEARCH: begin
        // Lock takes priority over a slip landing on the same cycle.
        if (cdec.is_token && (run_cnt == RUN_LAST)) begin
          state_next = LOCKED;
          run_next   = '0;
          dwell_next = '0;
          tmo_next   = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          offset_next = (offset == OFS_MAX) ? '0 : offset + 4'd1;
          run_next    = '0;
          dwell_next  = '0;
        end else begin
          run_next   = cdec.is_token ? run_cnt + 1'b1 : '0;
          dwell_next = dwell_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (cdec.is_token) begin
          tmo_next = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = SEARCH;
          tmo_next   = '0;
          run_next   = '0;
          dwell_next = '0;
        end else begin
          tmo_next = tmo_cnt + 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // Gating on the next state lets de drop on the same edge that locked falls.
  always_comb begin
    data_next = '0;
    de_next   = 1'b0;
    ctrl_next = cdec.is_token ? cdec.pair : ctrl;
    if ((state_next == LOCKED) && !cdec.is_token) begin
      data_next = ddec;
      de_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      ctrl <= '0;
      de   <= 1'b0;
    end else begin
      data <= data_next;
      ctrl <= ctrl_next;
      de   <= de_next;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock acquisition, near-miss slip,
// decode table, lock loss timing and asynchronous reset.
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN     = 16;
  localparam int DWELL        = 64;
  localparam int LOSS_TIMEOUT = 256;
  localparam int LOCK_BOUND   = 4*DWELL + CTRL_RUN + 2;
  localparam int LOCK_STEPS   = 3*DWELL + CTRL_RUN + 1;
  localparam int NV           = 12;

  logic       clk;
  logic       rst;
  logic [9:0] raw_in;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  int         shift;
  logic [9:0] prev_sym;
  int         n_cmp;
  int         n_fail;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } vec_t;

  vec_t vecs [NV];

  tmds_channel_decoder #(
    .CTRL_RUN     (CTRL_RUN),
    .DWELL        (DWELL),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .data   (data),
    .ctrl   (ctrl),
    .de     (de),
    .locked (locked),
    .offset (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serialize one symbol delayed by 'shift' bits into the raw word stream.
  task automatic step(input logic [9:0] sym);
    logic [19:0] cat;
    cat      = {sym, prev_sym} >> (10 - shift);
    raw_in   = cat[9:0];
    prev_sym = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    raw_in   = '0;
    prev_sym = '0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic acquire(input string name, input bit exact);
    int n;
    n     = 0;
    shift = 3;
    while (!locked && n < LOCK_BOUND) begin
      step(10'h354);
      n++;
    end
    check({name, "_locked"}, 32'(locked), 32'd1);
    if (exact) check({name, "_steps"}, n, LOCK_STEPS);
    check({name, "_offset"}, 32'(offset), 32'd3);
    check({name, "_ctrl"}, 32'(ctrl), 32'd0);
    check({name, "_de"}, 32'(de), 32'd0);
  endtask

  initial begin
    bit seen_lock;
    n_cmp  = 0;
    n_fail = 0;
    shift  = 0;

    vecs[0]  = '{10'h0FF, 8'hFF, 2'b00, 1'b1};
    vecs[1]  = '{10'h1FF, 8'h01, 2'b00, 1'b1};
    vecs[2]  = '{10'h300, 8'h01, 2'b00, 1'b1};
    vecs[3]  = '{10'h0AB, 8'h00, 2'b01, 1'b0};
    vecs[4]  = '{10'h154, 8'h00, 2'b10, 1'b0};
    vecs[5]  = '{10'h2AB, 8'h00, 2'b11, 1'b0};
    vecs[6]  = '{10'h0FF, 8'hFF, 2'b11, 1'b1};
    vecs[7]  = '{10'h0AA, 8'h00, 2'b11, 1'b1};
    vecs[8]  = '{10'h3F0, 8'h11, 2'b11, 1'b1};
    vecs[9]  = '{10'h155, 8'hFF, 2'b11, 1'b1};
    vecs[10] = '{10'h200, 8'hFF, 2'b11, 1'b1};
    vecs[11] = '{10'h354, 8'h00, 2'b00, 1'b0};

    rst = 1'b0;
    do_reset();
    check("rst_data", 32'(data), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_de", 32'(de), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);

    // Near-miss: 15 tokens then one data symbol, aligned at offset 0.
    shift     = 0;
    seen_lock = 1'b0;
    for (int n = 1; n <= 2*DWELL; n++) begin
      step(((n-1) % 16 == 15) ? 10'h0FF : 10'h354);
      if (locked) seen_lock = 1'b1;
      if (n == DWELL-1) check("nearmiss_offset_hold", 32'(offset), 32'd0);
      if (n == DWELL)   check("nearmiss_slip", 32'(offset), 32'd1);
    end
    check("nearmiss_no_lock", 32'(seen_lock), 32'd0);

    do_reset();
    acquire("acq", 1'b1);

    // Decode table: each symbol is visible exactly two steps after it is sent.
    for (int i = 0; i < NV+2; i++) begin
      step((i < NV) ? vecs[i].sym : 10'h354);
      if (i >= 2) begin
        check($sformatf("vec%0d_data", i-2), 32'(data), 32'(vecs[i-2].data));
        check($sformatf("vec%0d_ctrl", i-2), 32'(ctrl), 32'(vecs[i-2].ctrl));
        check($sformatf("vec%0d_de", i-2), 32'(de), 32'(vecs[i-2].de));
      end
    end

    // Lock loss: last token was just sent; now data only.
    for (int i = 1; i <= LOSS_TIMEOUT+2; i++) begin
      step(10'h0FF);
      if (i == LOSS_TIMEOUT+1) begin
        check("loss_still_locked", 32'(locked), 32'd1);
        check("loss_de_before", 32'(de), 32'd1);
      end
      if (i == LOSS_TIMEOUT+2) begin
        check("loss_unlocked", 32'(locked), 32'd0);
        check("loss_de_forced", 32'(de), 32'd0);
        check("loss_data_forced", 32'(data), 32'd0);
        check("loss_offset", 32'(offset), 32'd3);
      end
    end

    acquire("relock", 1'b0);
    step(10'h2AB);
    step(10'h0FF);
    step(10'h0FF);
    step(10'h0FF);
    check("pre_rst_de", 32'(de), 32'd1);
    check("pre_rst_ctrl", 32'(ctrl), 32'd3);
    check("pre_rst_data", 32'(data), 32'hFF);

    // Reset mid-cycle, well away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst_data", 32'(data), 32'd0);
    check("arst_ctrl", 32'(ctrl), 32'd0);
    check("arst_de", 32'(de), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_offset", 32'(offset), 32'd0);

    do_reset();
    check("reacq_start_offset", 32'(offset), 32'd0);
    acquire("reacq", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
